// File: rtl/riscv_muldiv_resp_unit.sv
// Pairs mul/div responses with in-order request tags and buffers the extracted
// 32-bit architectural result toward writeback.
module riscv_muldiv_resp_unit #(
    parameter int TAG_DEPTH = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_fire,
    input  logic [2:0]                   req_fn,
    input  logic [4:0]                   req_waddr,
    output logic                         tag_full,
    output logic [$clog2(TAG_DEPTH):0]   inflight,
    input  logic [63:0]                  muldivresp_msg_result,
    input  logic                         muldivresp_val,
    output logic                         muldivresp_rdy,
    output logic                         wb_val,
    input  logic                         wb_rdy,
    output logic [31:0]                  wb_data,
    output logic [4:0]                   wb_waddr,
    output logic                         proto_err
);
    localparam int TAW = $clog2(TAG_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [TAW:0]   TAG_CNT_ONE = (TAW+1)'(1);
    localparam logic [TAW:0]   TAG_CNT_MAX = (TAW+1)'(TAG_DEPTH);
    localparam logic [TAW-1:0] TAG_PTR_ONE = TAW'(1);
    localparam logic [OAW:0]   OUT_CNT_ONE = (OAW+1)'(1);
    localparam logic [OAW:0]   OUT_CNT_MAX = (OAW+1)'(OUT_DEPTH);
    localparam logic [OAW-1:0] OUT_PTR_ONE = OAW'(1);

    logic [7:0]     tag_mem [TAG_DEPTH];
    logic [TAW-1:0] tag_wr_ptr, tag_rd_ptr;
    logic [TAW:0]   tag_count;

    logic [36:0]    out_mem [OUT_DEPTH];
    logic [OAW-1:0] out_wr_ptr, out_rd_ptr;
    logic [OAW:0]   out_count;

    logic        tag_push, tag_pop, resp_go, out_push, out_pop;
    logic [2:0]  head_fn;
    logic [4:0]  head_waddr;
    logic [31:0] ext_data;
    logic        bad_fn;

    assign tag_full       = (tag_count == TAG_CNT_MAX);
    assign inflight       = tag_count;
    assign muldivresp_rdy = (out_count != OUT_CNT_MAX);
    assign wb_val         = (out_count != '0);
    assign {wb_data, wb_waddr} = out_mem[out_rd_ptr];

    assign resp_go  = muldivresp_val && muldivresp_rdy;
    assign tag_push = req_fire && !tag_full;
    // Pop uses the registered count, so a tag pushed this cycle cannot pair yet.
    assign tag_pop  = resp_go && (tag_count != '0);
    assign out_push = tag_pop;
    assign out_pop  = wb_val && wb_rdy;

    assign head_fn    = tag_mem[tag_rd_ptr][7:5];
    assign head_waddr = tag_mem[tag_rd_ptr][4:0];

    always_comb begin
        ext_data = '0;
        bad_fn   = 1'b0;
        case (head_fn)
            3'd0, 3'd1, 3'd2: ext_data = muldivresp_msg_result[31:0];
            3'd3, 3'd4:       ext_data = muldivresp_msg_result[63:32];
            default:          bad_fn   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
            for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
        end else begin
            if (tag_push) begin
                tag_mem[tag_wr_ptr] <= {req_fn, req_waddr};
                tag_wr_ptr          <= tag_wr_ptr + TAG_PTR_ONE;
            end
            if (tag_pop) tag_rd_ptr <= tag_rd_ptr + TAG_PTR_ONE;
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + TAG_CNT_ONE;
                2'b01:   tag_count <= tag_count - TAG_CNT_ONE;
                default: tag_count <= tag_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
        end else begin
            if (out_push) begin
                out_mem[out_wr_ptr] <= {ext_data, head_waddr};
                out_wr_ptr          <= out_wr_ptr + OUT_PTR_ONE;
            end
            if (out_pop) out_rd_ptr <= out_rd_ptr + OUT_PTR_ONE;
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + OUT_CNT_ONE;
                2'b01:   out_count <= out_count - OUT_CNT_ONE;
                default: out_count <= out_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            proto_err <= 1'b0;
        else if ((req_fire && tag_full) || (resp_go && !tag_pop) || (tag_pop && bad_fn))
            proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_riscv_muldiv_resp_unit.sv
// Directed-vector bench for riscv_muldiv_resp_unit.
module tb_riscv_muldiv_resp_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_fire;
    logic [2:0]  req_fn;
    logic [4:0]  req_waddr;
    logic        tag_full;
    logic [2:0]  inflight;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val;
    logic        muldivresp_rdy;
    logic        wb_val;
    logic        wb_rdy;
    logic [31:0] wb_data;
    logic [4:0]  wb_waddr;
    logic        proto_err;

    int checks = 0;
    int failures = 0;

    riscv_muldiv_resp_unit #(.TAG_DEPTH(4), .OUT_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .req_fire(req_fire), .req_fn(req_fn), .req_waddr(req_waddr),
        .tag_full(tag_full), .inflight(inflight),
        .muldivresp_msg_result(muldivresp_msg_result),
        .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
        .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_data(wb_data),
        .wb_waddr(wb_waddr), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [2:0] fn, input logic [4:0] wa);
        req_fire = 1'b1; req_fn = fn; req_waddr = wa;
        tick();
        req_fire = 1'b0;
    endtask

    task automatic respond(input logic [63:0] r);
        muldivresp_val = 1'b1; muldivresp_msg_result = r;
        tick();
        muldivresp_val = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_fire = 1'b0; req_fn = '0; req_waddr = '0;
        muldivresp_msg_result = '0; muldivresp_val = 1'b0; wb_rdy = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_tag_full", tag_full, 0);
        check("rst_inflight", inflight, 0);
        check("rst_wb_val", wb_val, 0);
        check("rst_rdy", muldivresp_rdy, 1);
        check("rst_err", proto_err, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_waddr", wb_waddr, 0);

        // Basic pairing
        issue(3'd0, 5'd5);
        check("basic_inflight1", inflight, 1);
        tick(); tick();
        respond(64'h0000_0001_0000_0006);
        check("basic_wb_val", wb_val, 1);
        check("basic_wb_data", wb_data, 6);
        check("basic_wb_waddr", wb_waddr, 5);
        check("basic_inflight0", inflight, 0);
        tick();
        check("basic_drained", wb_val, 0);

        // Extraction, back-to-back responses
        issue(3'd3, 5'd7);
        issue(3'd2, 5'd8);
        respond(64'h0000_0002_0000_0003);
        check("rem_data", wb_data, 2);
        check("rem_waddr", wb_waddr, 7);
        respond(64'h0000_0004_0000_0009);
        check("divu_val", wb_val, 1);
        check("divu_data", wb_data, 9);
        check("divu_waddr", wb_waddr, 8);
        tick();
        check("ext_drained", wb_val, 0);
        check("ext_err", proto_err, 0);

        // Backpressure
        wb_rdy = 1'b0;
        issue(3'd0, 5'd10);
        issue(3'd0, 5'd11);
        issue(3'd0, 5'd12);
        respond(64'd1);
        respond(64'd2);
        check("bp_rdy_low", muldivresp_rdy, 0);
        muldivresp_val = 1'b1; muldivresp_msg_result = 64'd3;
        tick();
        check("bp_rdy_still_low", muldivresp_rdy, 0);
        check("bp_head_held", wb_data, 1);
        check("bp_head_waddr", wb_waddr, 10);
        check("bp_inflight", inflight, 1);
        wb_rdy = 1'b1;
        tick();
        check("bp_rdy_up", muldivresp_rdy, 1);
        check("bp_second", wb_data, 2);
        check("bp_third_not_yet", inflight, 1);
        tick();
        muldivresp_val = 1'b0;
        check("bp_third_data", wb_data, 3);
        check("bp_third_waddr", wb_waddr, 12);
        check("bp_inflight0", inflight, 0);
        tick();
        check("bp_drained", wb_val, 0);

        // Tag full
        for (int i = 0; i < 4; i++) issue(3'd0, 5'(i + 1));
        check("full_flag", tag_full, 1);
        check("full_inflight", inflight, 4);
        check("full_err0", proto_err, 0);
        issue(3'd0, 5'd9);
        check("full_drop_inflight", inflight, 4);
        check("full_drop_err", proto_err, 1);
        for (int i = 0; i < 4; i++) begin
            respond(64'h10 + 64'(i));
            check("full_pair_data", wb_data, 64'h10 + 64'(i));
            check("full_pair_waddr", wb_waddr, 64'(i + 1));
        end
        tick();
        check("full_drained", wb_val, 0);
        check("full_inflight0", inflight, 0);
        do_reset();
        check("full_rst_err", proto_err, 0);

        // Response with no tags
        respond(64'h55);
        check("empty_wb_val", wb_val, 0);
        check("empty_err", proto_err, 1);
        check("empty_inflight", inflight, 0);
        do_reset();

        // Tag pushed alongside a response while empty is not paired
        req_fire = 1'b1; req_fn = 3'd0; req_waddr = 5'd4;
        respond(64'h77);
        req_fire = 1'b0;
        check("same_cyc_inflight", inflight, 1);
        check("same_cyc_wb_val", wb_val, 0);
        check("same_cyc_err", proto_err, 1);
        respond(64'h88);
        check("same_cyc_pair", wb_data, 64'h88);
        check("same_cyc_waddr", wb_waddr, 4);
        tick();
        do_reset();

        // Bad function code
        issue(3'd6, 5'd3);
        respond(64'hFFFF_FFFF_FFFF_FFFF);
        check("badfn_val", wb_val, 1);
        check("badfn_data", wb_data, 0);
        check("badfn_waddr", wb_waddr, 3);
        check("badfn_err", proto_err, 1);
        tick();
        do_reset();

        // Reset mid-stream
        wb_rdy = 1'b0;
        respond(64'h1);
        issue(3'd0, 5'd1);
        issue(3'd0, 5'd2);
        issue(3'd0, 5'd3);
        respond(64'hAB);
        check("mid_inflight", inflight, 2);
        check("mid_wb_val", wb_val, 1);
        check("mid_err", proto_err, 1);
        do_reset();
        check("mid_rst_inflight", inflight, 0);
        check("mid_rst_wb_val", wb_val, 0);
        check("mid_rst_rdy", muldivresp_rdy, 1);
        check("mid_rst_err", proto_err, 0);
        check("mid_rst_data", wb_data, 0);
        respond(64'hCD);
        check("mid_late_err", proto_err, 1);
        check("mid_late_wb_val", wb_val, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_muldiv_resp_unit.md
Name: riscv_muldiv_resp_unit

Overview:
Downstream consumer of the pipelined mul/div unit's 64-bit response stream. Records a tag for each issued request in an in-order tag FIFO: function code plus destination register. Pairs each returning 64-bit result with its tag and extracts the 32-bit architectural value. Buffers that value in a small output FIFO toward writeback, and drives muldivresp_rdy as backpressure into the mul/div pipeline.

Parameters:
TAG_DEPTH, 4, tag FIFO entries (power of two, >=2); bounds mul/div requests in flight
OUT_DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
req_fire  input  1  a mul/div request was accepted this cycle (muldivreq_val && muldivreq_rdy)
req_fn  input  3  function code of that request
req_waddr  input  5  destination register of that request
tag_full  output  1  tag FIFO full; issue must not assert req_fire
inflight  output  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
muldivresp_msg_result  input  64  result from mul/div unit
muldivresp_val  input  1  result valid
muldivresp_rdy  output  1  response accepted when high
wb_val  output  1  writeback entry valid
wb_rdy  input  1  writeback consumes entry when high
wb_data  output  32  extracted result
wb_waddr  output  5  destination register
proto_err  output  1  sticky protocol-error flag

Behaviour:
- Function codes: MUL=0, DIV=1, DIVU=2, REM=3, REMU=4.
- Extraction from the 64-bit result:
  - MUL, DIV, DIVU -> result[31:0].
  - REM, REMU -> result[63:32].
  - Codes 5-7 -> 32'h0 and set proto_err.
- Tag FIFO:
  - Push on req_fire && !tag_full; pop on resp_go = muldivresp_val && muldivresp_rdy.
  - tag_full = (count == TAG_DEPTH), computed from the registered count only. A same-cycle pop does not permit a push at full.
  - req_fire while tag_full: push dropped, proto_err set.
  - Push and pop in the same cycle (not full): count unchanged, pointers both advance and wrap modulo TAG_DEPTH.
- Pairing rules:
  - Each response pairs with the oldest tag; strict in-order completion.
  - resp_go with the tag FIFO empty: response consumed, nothing pushed to the output FIFO, proto_err set.
  - Exception to the above: a tag pushed in the same cycle as resp_go while empty is NOT eligible for pairing. Minimum tag-to-response latency is 1 cycle.
- Output FIFO:
  - muldivresp_rdy = !out_full, computed from the registered count only. No bypass of full through a same-cycle wb pop.
  - On resp_go, push {extracted data, tag waddr}.
  - Pop on wb_val && wb_rdy.
  - wb_val = !out_empty; wb_data and wb_waddr are driven from the head entry and held stable while wb_val && !wb_rdy.
  - Latency: a response accepted in cycle N is visible on wb in cycle N+1 at the earliest. No combinational path from muldivresp_* to wb_*.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
- waddr == 0 is delivered unchanged; writeback discards x0 writes.
- proto_err is sticky until reset.
- Reset (synchronous):
  - Counts and pointers cleared, so tag_full=0, inflight=0, wb_val=0, muldivresp_rdy=1, proto_err=0.
  - wb_data and wb_waddr reset to 0.
  - Reset mid-operation discards all in-flight tags and buffered results; any response arriving later is treated as tag-empty (proto_err).
- Throughput: one response per cycle sustained when wb_rdy stays high.

Test Plan:
- Basic pairing: req (MUL, waddr 5); 3 cycles later resp 64'h0000_0001_0000_0006 -> next cycle wb_val=1, wb_data=6, wb_waddr=5; inflight returns to 0.
- Extraction: REM waddr 7 then DIVU waddr 8, responses 64'h0000_0002_0000_0003 and 64'h0000_0004_0000_0009 -> wb entries (2,7) then (9,8), in order.
- Backpressure: wb_rdy=0, three back-to-back responses -> two buffered, muldivresp_rdy=0 on the third; third accepted one cycle after wb_rdy rises; data order preserved.
- Tag full: 4 req_fire with no responses -> tag_full=1, inflight=4. A fifth req_fire -> dropped and proto_err=1. The following 4 responses pair with the first 4 tags.
- Empty-tag response: resp_val with no tags -> accepted, wb_val stays 0, proto_err=1; bad fn=6 with resp -> wb_data=0, proto_err=1.
- Reset mid-stream: 2 tags and 1 buffered result, reset high 1 cycle -> inflight=0, wb_val=0, muldivresp_rdy=1, proto_err=0.
